dmem_responder: RTL and testbench

Memory-side responder for the core's data-memory port. Accepts one load or store request at a time over a valid/ready handshake and performs it after a fixed number of wait cycles. Applies byte, half or word masking and sign or zero extension, then returns the result over a second valid/ready handshake. It replaces the single-cycle data memory when the pipeline is run against a multi-cycle memory model.

---
 rtl/dmem_if.sv | 28 ++
 rtl/dmem_responder.sv | 149 ++++++++++++++
 tb/tb_dmem_responder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Data-memory request/response bundle between the core (master) and dmem_responder (slave).
// A transfer on either channel happens on a rising edge where valid && ready; once valid is high the
// sender holds its payload stable until that edge, and ready may depend on state but never on valid.
interface dmem_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [31:0]           req_addr;
    logic                  req_write;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [1:0]            req_maskmode;
    logic                  req_uext;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_addr, req_write, req_wdata, req_maskmode, req_uext, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata, req_maskmode, req_uext, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store at a time, fixed wait, byte/half/word lanes.
// Optional macro DMEM_MISALIGN_ERR_EN turns misaligned accesses into error responses.
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic       clk,
    input  logic       rstn,
    dmem_if.slave      bus,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH+1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [1:0]              mode_q;
    logic                    uext_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    accept;
    logic                    exec;
    logic                    misalign;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [3:0]              be;
    logic [DATA_WIDTH-1:0]   wr_word;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [7:0]              byte_v;
    logic [15:0]             half_v;
    logic [DATA_WIDTH-1:0]   load_val;
    logic                    unused_addr_hi;

    logic [DATA_WIDTH-1:0]   mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // req_ready is gated by rstn so nothing is accepted while reset is held.
    always_comb begin
        bus.req_ready  = rstn && (state == IDLE);
        bus.resp_valid = (state == RESP);
        exec           = (state == WAIT) && (cnt == 4'd0);
    end

    assign accept    = bus.req_valid && bus.req_ready;
    assign dbg_state = state;
    assign word_idx  = addr_q[ADDR_WIDTH+1:2];
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_WIDTH+2];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt     <= 4'd0;
            rdata_q <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            mode_q  <= 2'b00;
            uext_q  <= 1'b0;
        end else begin
            if (accept) begin
                cnt     <= 4'(LATENCY - 1);
                addr_q  <= bus.req_addr[ADDR_WIDTH+1:0];
                write_q <= bus.req_write;
                wdata_q <= bus.req_wdata;
                mode_q  <= bus.req_maskmode;
                uext_q  <= bus.req_uext;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (exec) rdata_q <= (write_q || misalign) ? '0 : load_val;
        end
    end

`ifdef DMEM_MISALIGN_ERR_EN
    logic err_q;
    assign misalign = (mode_q == 2'b01 && addr_q[0]) || (mode_q[1] && addr_q[1:0] != 2'b00);
    always_ff @(posedge clk) begin
        if (!rstn)     err_q <= 1'b0;
        else if (exec) err_q <= misalign;
    end
    assign bus.resp_err = err_q;
`else
    assign misalign     = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    assign bus.resp_rdata = rdata_q;

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        case (mode_q)
            2'b00: begin
                be      = 4'b0001 << addr_q[1:0];
                wr_word = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be      = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata_q[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                wr_word = wdata_q;
            end
        endcase
    end

    always_comb begin
        rd_word = mem[word_idx];
        case (addr_q[1:0])
            2'b00:   byte_v = rd_word[7:0];
            2'b01:   byte_v = rd_word[15:8];
            2'b10:   byte_v = rd_word[23:16];
            default: byte_v = rd_word[31:24];
        endcase
        half_v = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (mode_q)
            2'b00:   load_val = uext_q ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b01:   load_val = uext_q ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            default: load_val = rd_word;
        endcase
    end

    // rstn gating keeps a store whose execute edge coincides with reset from committing.
    always_ff @(posedge clk) begin
        if (rstn && exec && write_q && !misalign) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2): table of load/store vectors plus
// hand-written backpressure, reset-abort and misalignment sequences.
module tb_dmem_responder;
  logic       clk;
  logic       rstn;
  logic [1:0] dbg_state;
  int         passed;
  int         total;
  logic [31:0] exp_q[$];

  dmem_if #(.DATA_WIDTH(32)) bus();

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LATENCY(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    logic [1:0]  mode;
    logic        uext;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [1:0] mode, input logic uext);
    bus.req_addr     = addr;
    bus.req_write    = wr;
    bus.req_wdata    = wd;
    bus.req_maskmode = mode;
    bus.req_uext     = uext;
    bus.req_valid    = 1'b1;
  endtask

  // Full transaction with resp_ready high; lat counts cycles from accept to resp_valid.
  task automatic txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                     input logic [1:0] mode, input logic uext,
                     output logic [31:0] rdata, output logic err, output int lat,
                     output logic rdy_ok, output logic ok);
    int n;
    rdy_ok = 1'b1; ok = 1'b1; lat = 0; rdata = '0; err = 1'b0;
    @(negedge clk);
    drive(addr, wr, wd, mode, uext);
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin bus.req_valid = 1'b0; ok = 1'b0; return; end
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 50) begin
      if (bus.req_ready) rdy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!bus.resp_valid) begin ok = 1'b0; return; end
    if (bus.req_ready) rdy_ok = 1'b0;
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        rdy_ok;
    logic        ok;
    logic [31:0] exp;

    passed = 0; total = 0;
    rstn = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0; bus.req_wdata = '0;
    bus.req_maskmode = 2'b00; bus.req_uext = 1'b0; bus.resp_ready = 1'b1;

    vecs[0]  = '{32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0000_0000};
    vecs[1]  = '{32'h0000_0010, 1'b0, 32'h0,         2'b10, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{32'h0000_0010, 1'b1, 32'h0000_0000, 2'b10, 1'b0, 32'h0000_0000};
    vecs[3]  = '{32'h0000_0013, 1'b1, 32'h1234_5680, 2'b00, 1'b0, 32'h0000_0000};
    vecs[4]  = '{32'h0000_0010, 1'b0, 32'h0,         2'b10, 1'b0, 32'h8000_0000};
    vecs[5]  = '{32'h0000_0013, 1'b0, 32'h0,         2'b00, 1'b0, 32'hFFFF_FF80};
    vecs[6]  = '{32'h0000_0013, 1'b0, 32'h0,         2'b00, 1'b1, 32'h0000_0080};
    vecs[7]  = '{32'h0000_0012, 1'b0, 32'h0,         2'b01, 1'b0, 32'hFFFF_8000};
    vecs[8]  = '{32'h0000_0012, 1'b0, 32'h0,         2'b01, 1'b1, 32'h0000_8000};
    vecs[9]  = '{32'h0000_0012, 1'b0, 32'h0,         2'b00, 1'b1, 32'h0000_0000};
    vecs[10] = '{32'h0000_0010, 1'b1, 32'h5555_ABCD, 2'b01, 1'b0, 32'h0000_0000};
    vecs[11] = '{32'h0000_0010, 1'b0, 32'h0,         2'b11, 1'b1, 32'h8000_ABCD};
    vecs[12] = '{32'h0000_0010, 1'b0, 32'h0,         2'b01, 1'b0, 32'hFFFF_ABCD};
    vecs[13] = '{32'h0000_0020, 1'b1, 32'h1111_1111, 2'b10, 1'b0, 32'h0000_0000};
    vecs[14] = '{32'h0000_1004, 1'b1, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0000_0000};
    vecs[15] = '{32'h0000_0004, 1'b0, 32'h0,         2'b10, 1'b0, 32'hCAFE_F00D};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.req_ready", {31'b0, bus.req_ready}, 32'd0);
    check("reset.resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("reset.resp_rdata", bus.resp_rdata, 32'd0);
    check("reset.resp_err", {31'b0, bus.resp_err}, 32'd0);
    check("reset.state", {30'b0, dbg_state}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("idle.req_ready", {31'b0, bus.req_ready}, 32'd1);

    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(vecs[i].exp);
      txn(vecs[i].addr, vecs[i].wr, vecs[i].wd, vecs[i].mode, vecs[i].uext, rdata, err, lat, rdy_ok, ok);
      exp = exp_q.pop_front();
      check($sformatf("vec%0d.done", i), {31'b0, ok}, 32'd1);
      check($sformatf("vec%0d.rdata", i), rdata, exp);
      check($sformatf("vec%0d.err", i), {31'b0, err}, 32'd0);
      check($sformatf("vec%0d.latency", i), lat, 32'd3);
      check($sformatf("vec%0d.ready_low", i), {31'b0, rdy_ok}, 32'd1);
    end

    // Backpressure: response stalled 5 cycles while a new request waits on the bus.
    @(negedge clk);
    bus.resp_ready = 1'b0;
    drive(32'h0000_0010, 1'b0, 32'h0, 2'b10, 1'b0);
    check("bp.ready_idle", {31'b0, bus.req_ready}, 32'd1);
    @(negedge clk);
    drive(32'h0000_0004, 1'b0, 32'h0, 2'b10, 1'b0);
    lat = 1;
    while (!bus.resp_valid && lat < 50) begin @(negedge clk); lat++; end
    check("bp.latency", lat, 32'd3);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp.stall%0d.rdata", k), bus.resp_rdata, 32'h8000_ABCD);
      check($sformatf("bp.stall%0d.valid", k), {31'b0, bus.resp_valid}, 32'd1);
      check($sformatf("bp.stall%0d.req_ready", k), {31'b0, bus.req_ready}, 32'd0);
      @(negedge clk);
    end
    check("bp.rdata_end", bus.resp_rdata, 32'h8000_ABCD);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp.first_idle.state", {30'b0, dbg_state}, 32'd0);
    check("bp.first_idle.req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("bp.first_idle.resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("bp.second.accepted", {30'b0, dbg_state}, 32'd1);
    lat = 1;
    while (!bus.resp_valid && lat < 50) begin @(negedge clk); lat++; end
    check("bp.second.latency", lat, 32'd3);
    check("bp.second.rdata", bus.resp_rdata, 32'hCAFE_F00D);
    @(posedge clk);

    // Reset during WAIT of a store aborts it.
    @(negedge clk);
    drive(32'h0000_0020, 1'b1, 32'h2222_2222, 2'b10, 1'b0);
    check("rst.ready_before", {31'b0, bus.req_ready}, 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    check("rst.resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst.req_ready", {31'b0, bus.req_ready}, 32'd0);
    check("rst.state", {30'b0, dbg_state}, 32'd0);
    rstn = 1'b1;
    txn(32'h0000_0020, 1'b0, 32'h0, 2'b10, 1'b0, rdata, err, lat, rdy_ok, ok);
    check("rst.load.done", {31'b0, ok}, 32'd1);
    check("rst.load.rdata", rdata, 32'h1111_1111);

    // Misaligned word store at 0x22, then word load at 0x20.
    txn(32'h0000_0022, 1'b1, 32'h3333_3333, 2'b10, 1'b0, rdata, err, lat, rdy_ok, ok);
    check("mis.store.done", {31'b0, ok}, 32'd1);
    check("mis.store.rdata", rdata, 32'd0);
    check("mis.store.latency", lat, 32'd3);
`ifdef DMEM_MISALIGN_ERR_EN
    check("mis.store.err", {31'b0, err}, 32'd1);
    exp = 32'h1111_1111;
`else
    check("mis.store.err", {31'b0, err}, 32'd0);
    exp = 32'h3333_3333;
`endif
    txn(32'h0000_0020, 1'b0, 32'h0, 2'b10, 1'b0, rdata, err, lat, rdy_ok, ok);
    check("mis.load.done", {31'b0, ok}, 32'd1);
    check("mis.load.rdata", rdata, exp);
    check("mis.load.err", {31'b0, err}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
